chip8_alu_sequencer: RTL and testbench

Executes CHIP-8 8XYN arithmetic/logic instructions. It owns the operand side of the CHIP-8 ALU. It reads VX and VY from the V-register file through one synchronous read port, drives the ALU operands and operation code, and samples the ALU result and carry. It then writes the result back to VX and, where the instruction defines a flag, writes the carry or borrow to VF. It sits between the instruction decoder and the register file / ALU pair.

---
 rtl/chip8_alu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_chip8_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_sequencer.sv
// CHIP-8 8XYN sequencer: reads VX/VY through one synchronous read port, drives the
// external ALU, then writes the result to VX and, for flag-producing ops, the flag to VF.
module chip8_alu_sequencer #(
   parameter logic [3:0] FLAG_REG       = 4'hF,
   parameter bit         VF_RESET_LOGIC = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [15:0] instr_i,
   output logic        ready_o,
   output logic        done_o,
   output logic        err_o,
   output logic [3:0]  rf_raddr_o,
   input  logic [7:0]  rf_rdata_i,
   output logic        rf_we_o,
   output logic [3:0]  rf_waddr_o,
   output logic [7:0]  rf_wdata_o,
   output logic [7:0]  alu_x_o,
   output logic [7:0]  alu_y_o,
   output logic [2:0]  alu_op_o,
   input  logic [7:0]  alu_out_i,
   input  logic        alu_carry_i
);

   typedef enum logic [2:0] {
      StIdle, StRdX, StRdY, StCapY, StExec, StWrX, StWrF, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  x_q, y_q, n_q;
   logic        illegal_q;
   logic [3:0]  raddr_q;
   logic [7:0]  vx_q;
   logic [7:0]  alu_x_q, alu_y_q;
   logic [2:0]  alu_op_q;
   logic [7:0]  res_q;
   logic        flag_q;

   logic        accept;
   logic        legal_in;
   logic [2:0]  dec_op;
   logic        dec_swap;
   logic        dec_flag;
   logic        dec_zero;

   assign accept = (state_q == StIdle) && start_i;

   // Legality is judged on the incoming word so illegal ops never touch the read port.
   always_comb begin
      legal_in = 1'b0;
      if (instr_i[15:12] == 4'h8) begin
         legal_in = (instr_i[3] == 1'b0) || (instr_i[3:0] == 4'hE);
      end
   end

   // Decode the latched N into ALU op, operand swap and flag behaviour.
   always_comb begin
      dec_op   = 3'd0;
      dec_swap = 1'b0;
      dec_flag = 1'b0;
      dec_zero = 1'b0;
      case (n_q)
         4'h0: dec_op = 3'd0;
         4'h1, 4'h2, 4'h3: begin
            dec_op   = n_q[2:0];
            dec_flag = VF_RESET_LOGIC;
            dec_zero = 1'b1;
         end
         4'h4, 4'h5, 4'h6: begin
            dec_op   = n_q[2:0];
            dec_flag = 1'b1;
         end
         4'h7: begin
            dec_op   = 3'd5;
            dec_swap = 1'b1;
            dec_flag = 1'b1;
         end
         4'hE: begin
            dec_op   = 3'd7;
            dec_flag = 1'b1;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; illegal ops spend one cycle in RdX without reading, then finish.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StRdX;
         StRdX:   state_d = illegal_q ? StDone : StRdY;
         StRdY:   state_d = StCapY;
         StCapY:  state_d = StExec;
         StExec:  state_d = StWrX;
         StWrX:   state_d = dec_flag ? StWrF : StDone;
         StWrF:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath registers: instruction fields, read address, operands and ALU result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q       <= 4'd0;
         y_q       <= 4'd0;
         n_q       <= 4'd0;
         illegal_q <= 1'b0;
         raddr_q   <= 4'd0;
         vx_q      <= 8'd0;
         alu_x_q   <= 8'd0;
         alu_y_q   <= 8'd0;
         alu_op_q  <= 3'd0;
         res_q     <= 8'd0;
         flag_q    <= 1'b0;
      end else begin
         if (accept) begin
            x_q       <= instr_i[11:8];
            y_q       <= instr_i[7:4];
            n_q       <= instr_i[3:0];
            illegal_q <= !legal_in;
            if (legal_in) raddr_q <= instr_i[11:8];
         end
         if (state_q == StRdX && !illegal_q) raddr_q <= y_q;
         if (state_q == StRdY) vx_q <= rf_rdata_i;
         // rf_rdata_i holds VY here; operands are presented to the ALU during EXEC.
         if (state_q == StCapY) begin
            alu_x_q  <= dec_swap ? rf_rdata_i : vx_q;
            alu_y_q  <= dec_swap ? vx_q : rf_rdata_i;
            alu_op_q <= dec_op;
         end
         if (state_q == StExec) begin
            res_q  <= alu_out_i;
            flag_q <= dec_zero ? 1'b0 : alu_carry_i;
         end
      end
   end

   // Register-file write port and status outputs.
   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = 4'd0;
      rf_wdata_o = 8'd0;
      if (state_q == StWrX) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = x_q;
         rf_wdata_o = res_q;
      end else if (state_q == StWrF) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = FLAG_REG;
         rf_wdata_o = {7'b0, flag_q};
      end
   end

   assign ready_o    = (state_q == StIdle);
   assign done_o     = (state_q == StDone);
   assign err_o      = (state_q == StDone) && illegal_q;
   assign rf_raddr_o = raddr_q;
   assign alu_x_o    = alu_x_q;
   assign alu_y_o    = alu_y_q;
   assign alu_op_o   = alu_op_q;

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Bench for chip8_alu_sequencer: register-file and ALU models around the DUT, with an
// instruction-level reference that queues expected writes checked as the DUT writes.
module tb_chip8_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] instr;
   logic        ready, done, err;
   logic [3:0]  rf_raddr;
   logic [7:0]  rf_rdata;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic [7:0]  alu_x, alu_y, alu_out;
   logic [2:0]  alu_op;
   logic        alu_carry;

   logic [7:0]  regs [16];
   logic        pl_we;
   logic [3:0]  pl_addr;
   logic [7:0]  pl_data;

   logic [11:0] exp_q [$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   chip8_alu_sequencer dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .instr_i     (instr),
      .ready_o     (ready),
      .done_o      (done),
      .err_o       (err),
      .rf_raddr_o  (rf_raddr),
      .rf_rdata_i  (rf_rdata),
      .rf_we_o     (rf_we),
      .rf_waddr_o  (rf_waddr),
      .rf_wdata_o  (rf_wdata),
      .alu_x_o     (alu_x),
      .alu_y_o     (alu_y),
      .alu_op_o    (alu_op),
      .alu_out_i   (alu_out),
      .alu_carry_i (alu_carry)
   );

   // Register file: synchronous read, DUT write port, bench preload port.
   always @(posedge clk) begin
      rf_rdata <= regs[rf_raddr];
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      else if (pl_we) regs[pl_addr] <= pl_data;
   end

   // ALU model.
   always_comb begin
      alu_out   = 8'd0;
      alu_carry = 1'b0;
      case (alu_op)
         3'd0: alu_out = alu_y;
         3'd1: alu_out = alu_x | alu_y;
         3'd2: alu_out = alu_x & alu_y;
         3'd3: alu_out = alu_x ^ alu_y;
         3'd4: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
         3'd5: begin alu_out = alu_x - alu_y; alu_carry = (alu_x > alu_y); end
         3'd6: begin alu_out = alu_x >> 1; alu_carry = alu_x[0]; end
         default: begin alu_out = alu_x << 1; alu_carry = alu_x[7]; end
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every DUT write must match the head of the expected-write queue.
   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         check_eq("write_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check_eq("write_addr_data", {rf_waddr, rf_wdata}, exp_q.pop_front());
      end
   end

   task automatic preload(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask

   // Instruction-level reference (VF_RESET_LOGIC = 0): queues writes, returns latency.
   task automatic push_expected(input logic [15:0] ins, output int lat, output logic e);
      logic [3:0] x, y, n;
      logic [7:0] vx, vy, r;
      logic [8:0] t;
      logic       c, hf;
      x = ins[11:8]; y = ins[7:4]; n = ins[3:0];
      vx = regs[x]; vy = regs[y];
      r = 8'd0; c = 1'b0; hf = 1'b1; e = 1'b0;
      if (ins[15:12] != 4'h8 || (n >= 4'h8 && n != 4'hE)) begin
         e = 1'b1; lat = 2;
         return;
      end
      case (n)
         4'h0: begin r = vy; hf = 1'b0; end
         4'h1: begin r = vx | vy; hf = 1'b0; end
         4'h2: begin r = vx & vy; hf = 1'b0; end
         4'h3: begin r = vx ^ vy; hf = 1'b0; end
         4'h4: begin t = {1'b0, vx} + {1'b0, vy}; r = t[7:0]; c = t[8]; end
         4'h5: begin r = vx - vy; c = (vx > vy); end
         4'h6: begin r = {1'b0, vx[7:1]}; c = vx[0]; end
         4'h7: begin r = vy - vx; c = (vy > vx); end
         default: begin r = {vx[6:0], 1'b0}; c = vx[7]; end
      endcase
      exp_q.push_back({x, r});
      if (hf) exp_q.push_back({4'hF, 7'b0, c});
      lat = hf ? 7 : 6;
   endtask

   task automatic run_instr(input logic [15:0] ins, input bit hold);
      int   exp_lat, cyc;
      logic exp_err;
      bit   got;
      @(negedge clk);
      check_eq("ready_before", ready, 1);
      push_expected(ins, exp_lat, exp_err);
      start = 1'b1; instr = ins; cyc = 0; got = 1'b0;
      while (!got && cyc < 16) begin
         @(posedge clk); #1;
         cyc++;
         if (!hold) start = 1'b0;
         if (done) got = 1'b1;
         else check_eq("ready_busy", ready, 0);
      end
      start = 1'b0;
      check_eq($sformatf("latency_%h", ins), got ? cyc : 0, exp_lat);
      check_eq($sformatf("err_%h", ins), err, exp_err);
      @(posedge clk); #1;
      check_eq("ready_after", ready, 1);
      check_eq("done_pulse", done, 0);
      check_eq("writes_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] nl [9];
      logic [15:0] ins;
      nl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
      rst_n = 1'b0; start = 1'b0; instr = 16'h0;
      pl_we = 1'b0; pl_addr = 4'h0; pl_data = 8'h0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", ready, 1);
      check_eq("rst_done_err", {done, err}, 0);
      check_eq("rst_we", rf_we, 0);
      check_eq("rst_addr_data", {rf_raddr, rf_waddr, rf_wdata}, 0);
      check_eq("rst_alu", {alu_x, alu_y, alu_op}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) preload(i[3:0], 8'h00);

      preload(4'h0, 8'h10); preload(4'h1, 8'h20);
      run_instr(16'h8014, 1'b0);
      check_eq("v0_8014", regs[0], 8'h30);
      check_eq("vf_8014", regs[15], 8'h00);

      preload(4'h2, 8'hF0); preload(4'h3, 8'h20);
      run_instr(16'h8234, 1'b0);
      check_eq("v2_8234", regs[2], 8'h10);
      check_eq("vf_8234", regs[15], 8'h01);

      preload(4'h2, 8'h05); preload(4'h3, 8'h05);
      run_instr(16'h8235, 1'b0);
      check_eq("v2_8235", regs[2], 8'h00);
      check_eq("vf_8235", regs[15], 8'h00);

      preload(4'h4, 8'h03); preload(4'h5, 8'h0A);
      run_instr(16'h8457, 1'b0);
      check_eq("alu_ops_8457", {alu_x, alu_y, 5'b0, alu_op}, {8'h0A, 8'h03, 8'h05});
      check_eq("v4_8457", regs[4], 8'h07);
      check_eq("vf_8457", regs[15], 8'h01);

      preload(4'hF, 8'h81);
      run_instr(16'h8F06, 1'b0);
      check_eq("vf_8f06", regs[15], 8'h01);

      preload(4'h1, 8'h3C); preload(4'h2, 8'h0F); preload(4'hF, 8'h55);
      run_instr(16'h8123, 1'b0);
      check_eq("v1_8123", regs[1], 8'h33);
      check_eq("vf_8123_untouched", regs[15], 8'h55);

      run_instr(16'h8128, 1'b0);
      run_instr(16'h9120, 1'b0);
      preload(4'h1, 8'h11); preload(4'h2, 8'hAB);
      run_instr(16'h8120, 1'b1);
      check_eq("v1_8120_hold", regs[1], 8'hAB);

      for (int i = 0; i < 10; i++) begin
         ins = {4'h8, 4'($urandom_range(15)), 4'($urandom_range(15)), nl[$urandom_range(8)]};
         preload(ins[11:8], 8'($urandom));
         preload(ins[7:4], 8'($urandom));
         run_instr(ins, 1'b0);
      end

      // Reset during WR_X must abort without writing.
      preload(4'h0, 8'h11); preload(4'h1, 8'h22); preload(4'hF, 8'h77);
      @(negedge clk);
      start = 1'b1; instr = 16'h8014;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_eq("we_in_wrx", rf_we, 1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_we", rf_we, 0);
      check_eq("abort_ready", ready, 1);
      check_eq("abort_done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_eq("abort_v0", regs[0], 8'h11);
      check_eq("abort_vf", regs[15], 8'h77);
      run_instr(16'h8011, 1'b0);
      check_eq("v0_8011", regs[0], 8'h33);
      check_eq("vf_8011", regs[15], 8'h77);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
